// File: rtl/output_buffer_unit.sv
// output_buffer_unit: buffered terminal output unit for the ASIP16 CU.
// Values arrive over a four-phase out_req/out_ack handshake, are queued in a
// DEPTH-entry FIFO with their display format, and are drained one at a time
// by a print FSM that pulses disp_valid for each printed entry.
// Optional macro OUT_FLUSH_EN adds a synchronous active-high flush input.
module output_buffer_unit #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic                       clk,
  input  logic                       rst_b,
`ifdef OUT_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       out_req,
  input  logic [DW-1:0]              out_data,
  input  logic [1:0]                 out_fmt,
  output logic                       out_ack,
  output logic                       full,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       disp_valid,
  output logic [DW-1:0]              disp_data,
  output logic [1:0]                 disp_fmt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic {A_IDLE, A_ACK} a_state_t;
  typedef enum logic [1:0] {D_IDLE, D_EMIT, D_GAP} d_state_t;

  a_state_t       a_state, a_next;
  d_state_t       d_state, d_next;
  logic [DW+1:0]  mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt, cnt_next;
  logic           full_r;
  logic           push, pop, flush_i;
  logic [7:0]     gap_cnt, gap_next;
  logic [DW-1:0]  hold_data;
  logic [1:0]     hold_fmt;

`ifdef OUT_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Accept FSM: one push per handshake; a flushed push is still acknowledged
  always_comb begin
    a_next = a_state;
    push   = 1'b0;
    case (a_state)
      A_IDLE: if (out_req && !full_r) begin
        push   = !flush_i;
        a_next = A_ACK;
      end
      A_ACK:  if (!out_req) a_next = A_IDLE;
      default: a_next = A_IDLE;
    endcase
  end

  // Drain FSM: pop head, emit for one cycle, then optionally idle GAP cycles
  always_comb begin
    d_next   = d_state;
    pop      = 1'b0;
    gap_next = gap_cnt;
    case (d_state)
      D_IDLE: if (cnt != '0 && !flush_i) begin
        pop    = 1'b1;
        d_next = D_EMIT;
      end
      D_EMIT: begin
        if (GAP == 0) begin
          d_next = D_IDLE;
        end else begin
          gap_next = 8'(GAP - 1);
          d_next   = D_GAP;
        end
      end
      D_GAP: begin
        if (gap_cnt == '0) d_next = D_IDLE;
        else               gap_next = gap_cnt - 8'd1;
      end
      default: d_next = D_IDLE;
    endcase
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    cnt_next = cnt;
    if (push && !pop)      cnt_next = cnt + CW'(1);
    else if (pop && !push) cnt_next = cnt - CW'(1);
  end

  // State registers for both FSMs and the gap counter
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_state <= A_IDLE;
      d_state <= D_IDLE;
      gap_cnt <= '0;
    end else begin
      a_state <= a_next;
      d_state <= d_next;
      gap_cnt <= gap_next;
    end
  end

  // FIFO pointers, occupancy and registered full flag
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full_r <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt    <= cnt_next;
      full_r <= (cnt_next == CW'(DEPTH));
    end
  end

  // FIFO storage, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {out_fmt, out_data};
  end

  // Holding register doubles as the displayed value; it changes only on pop,
  // which coincides with entry into D_EMIT
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hold_data <= '0;
      hold_fmt  <= '0;
    end else if (pop) begin
      {hold_fmt, hold_data} <= mem[rd_ptr];
    end
  end

`ifndef SYNTHESIS
  // Simulation print of the entry being emitted
  always_ff @(posedge clk) begin
    if (rst_b && d_state == D_EMIT) begin
      case (hold_fmt)
        2'b00:   $display("[OUTPUT_UNIT] OUT> %0d", hold_data);
        2'b01:   $display("[OUTPUT_UNIT] OUT> 0x%h", hold_data);
        2'b10:   $display("[OUTPUT_UNIT] OUT> 0b%b", hold_data);
        default: $display("[OUTPUT_UNIT] OUT> %0d", $signed(hold_data));
      endcase
    end
  end
`endif

  assign out_ack    = (a_state == A_ACK);
  assign full       = full_r;
  assign count      = cnt;
  assign busy       = (cnt != '0) || (d_state != D_IDLE);
  assign disp_valid = (d_state == D_EMIT);
  assign disp_data  = hold_data;
  assign disp_fmt   = hold_fmt;

endmodule

// File: tb/tb_output_buffer_unit.sv
// Self-checking bench for output_buffer_unit (DEPTH=4, GAP=10).
// Expected prints come from a FIFO-order queue of accepted values.
module tb_output_buffer_unit;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 10;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          out_req = 1'b0;
  logic [DW-1:0] out_data = '0;
  logic [1:0]    out_fmt = '0;
  logic          out_ack, full, busy, disp_valid;
  logic [CW-1:0] count;
  logic [DW-1:0] disp_data;
  logic [1:0]    disp_fmt;
`ifdef OUT_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int            checks = 0;
  int            errors = 0;
  int            prints = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] last_data = '0;
  logic [1:0]    last_fmt = '0;
  logic          prev_valid = 1'b0;
  logic          saw_full = 1'b0;

  output_buffer_unit #(.DW(DW), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk),
    .rst_b(rst_b),
`ifdef OUT_FLUSH_EN
    .flush(flush),
`endif
    .out_req(out_req),
    .out_data(out_data),
    .out_fmt(out_fmt),
    .out_ack(out_ack),
    .full(full),
    .busy(busy),
    .count(count),
    .disp_valid(disp_valid),
    .disp_data(disp_data),
    .disp_fmt(disp_fmt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_ack",   32'(out_ack), 32'd0);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_data",  32'(disp_data), 32'd0);
    chk("rst_fmt",   32'(disp_fmt), 32'd0);
  endtask

  // Print monitor: each disp_valid pulse must match the oldest accepted value
  always @(negedge clk) begin
    if (!rst_b) begin
      last_data  = '0;
      last_fmt   = '0;
      prev_valid = 1'b0;
    end else begin
      chk("full_vs_count", 32'(full), 32'(32'(count) == DEPTH));
      if (full) saw_full = 1'b1;
      if (disp_valid) begin
        logic [DW+1:0] e;
        prints++;
        chk("valid_pulse", 32'(prev_valid), 32'd0);
        chk("print_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("disp_data", 32'(disp_data), 32'(e[DW-1:0]));
          chk("disp_fmt",  32'(disp_fmt),  32'(e[DW+1:DW]));
          last_data = e[DW-1:0];
          last_fmt  = e[DW+1:DW];
        end
      end else begin
        chk("disp_hold", 32'({disp_fmt, disp_data}), 32'({last_fmt, last_data}));
      end
      prev_valid = disp_valid;
    end
  end

  // Full four-phase handshake for one value; called at a negedge
  task automatic send(input logic [DW-1:0] d, input logic [1:0] f, input int unsigned hold);
    logic        was_full;
    int unsigned n = 0;
    out_data = d;
    out_fmt  = f;
    out_req  = 1'b1;
    do begin
      was_full = full;
      @(negedge clk);
      if (was_full) begin
        chk("ack_withheld", 32'(out_ack), 32'd0);
        n++;
      end
    end while (was_full && n < 500);
    chk("accept_timeout", 32'(was_full), 32'd0);
    chk("ack_after_accept", 32'(out_ack), 32'd1);
    exp_q.push_back({f, d});
    out_data = DW'($urandom);
    out_fmt  = 2'($urandom);
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("ack_hold", 32'(out_ack), 32'd1);
    end
    out_req = 1'b0;
    @(negedge clk);
    chk("ack_drop", 32'(out_ack), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 3000), 32'd1);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_busy",  32'(busy), 32'd0);
    chk("idle_full",  32'(full), 32'd0);
    chk("idle_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int prints_before;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    #2 rst_b = 1'b1;
    @(negedge clk);

    // Single unsigned value
    send(16'd1234, 2'b00, 0);
    wait_idle();

    // Each display format in order
    send(16'hFFFF, 2'b11, 1);
    send(16'h00AF, 2'b01, 0);
    send(16'd5,    2'b10, 2);
    wait_idle();

    // Back-to-back requests fill the FIFO and stall the handshake
    saw_full = 1'b0;
    for (int unsigned i = 0; i < 6; i++) send(DW'($urandom), 2'($urandom), 0);
    chk("saw_full", 32'(saw_full), 32'd1);
    wait_idle();

    // Randomized traffic
    for (int unsigned i = 0; i < 20; i++) begin
      send(DW'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 2));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_idle();

    // Reset with three entries queued (one already popped for printing)
    for (int unsigned i = 0; i < 4; i++) send(DW'($urandom), 2'($urandom), 0);
    chk("queued_before_reset", 32'(count), 32'd3);
    #2 rst_b = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs();
    @(negedge clk);
    #2 rst_b = 1'b1;
    prints_before = prints;
    repeat (80) @(negedge clk);
    chk("no_print_after_reset", 32'(prints), 32'(prints_before));
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
